preg_freelist_2w: RTL and testbench
===================================

# preg_freelist_2w

Dual-ported physical register free list for the rename/commit unit. Rename pops up to two free physical tags per cycle on a speculative read pointer. Commit advances a committed read pointer and pushes up to two released tags back. A flush restores the speculative pointer to the committed one, so tags allocated by squashed instructions are reclaimed in one cycle.

## Interface
Parameters:
- FL_SIZE, 32, number of free-list entries; power of two
- FL_SIZE_WIDTH, 5, log2(FL_SIZE)
- TAG_WIDTH, 6, physical register tag width
- FIRST_FREE_TAG, 32, tag held by entry 0 after reset; entry i holds FIRST_FREE_TAG+i

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- alloc_req_i  in  2  {second, first} allocation requests from rename
- alloc_gnt_o  out  1  all requested tags granted this cycle
- alloc_tag_first_o  out  TAG_WIDTH  tag for first lane
- alloc_tag_second_o  out  TAG_WIDTH  tag for second lane
- commit_i  in  2  {second, first} commit of instructions that allocated a tag
- free_i  in  2  {second, first} tag release at commit
- free_tag_first_i  in  TAG_WIDTH  released tag, first lane
- free_tag_second_i  in  TAG_WIDTH  released tag, second lane
- flush_i  in  1  squash all uncommitted allocations
- free_num_o  out  FL_SIZE_WIDTH+1  speculatively available tags
- fl_empty_o  out  1  free_num_o == 0
- fl_almost_empty_o  out  1  free_num_o <= 1
- err_o  out  1  sticky protocol-violation flag

## Operation
- State: queue[FL_SIZE] of tags and three (FL_SIZE_WIDTH+1)-bit pointers: spec_head, com_head, tail. The MSB is the wrap bit; the low bits index the queue.
- Counts: free_num_o = tail - spec_head; committed count = tail - com_head; in-flight = spec_head - com_head. All arithmetic is modulo 2^(FL_SIZE_WIDTH+1).
- Reset: queue[i] = FIRST_FREE_TAG+i; spec_head = com_head = 0; tail = FL_SIZE (wrap bit set, index 0). The list starts full, so free_num_o = FL_SIZE.
- Allocation is all-or-nothing. n_alloc = popcount(alloc_req_i).
  - alloc_gnt_o = (n_alloc != 0) & (free_num_o >= n_alloc) & !flush_i.
  - Lanes compact: the first requesting lane receives queue[spec_head], and the second receives queue[spec_head+1] only when both lanes request. If only second requests, alloc_tag_second_o = queue[spec_head].
  - Tags that are not requested drive 0.
- On grant, spec_head += n_alloc. With no grant, spec_head is unchanged and the tags are don't-care to the consumer.
- Commit: com_head += popcount(commit_i).
- Free: released tags are compacted and written at tail and tail+1 (with wrap), and tail += popcount(free_i). A lone second-lane release is written at tail.
- Flush: spec_head <= com_head plus any same-cycle commit. Allocation in the flush cycle is suppressed. Free and commit in that cycle still apply.
- err_o is set, and held until reset, on any of:
  - a free that would make committed count > FL_SIZE; the write is dropped and tail is unchanged;
  - popcount(commit_i) > in-flight; com_head is clamped to spec_head.

## Timing
- Tags, alloc_gnt_o and flags are combinational from current state and inputs, with zero latency.
- Pointer and queue updates take effect at the next rising edge.
- Freed tags are allocatable one cycle after the free; there is no same-cycle bypass. free_num_o in a cycle with simultaneous alloc and free reflects the pre-edge state.
- Wrap-around: index FL_SIZE-1 is followed by 0 and the wrap bit toggles. A pair access straddling the end uses entries FL_SIZE-1 and 0.
- Reset during operation: all pointers, queue contents and err_o return to reset values on the edge where rst_n=0. Inputs are ignored in that cycle.

## Test plan
- Reset, then alloc_req_i=2'b11 -> alloc_gnt_o=1, tags 32/33. Next cycle free_num_o=30.
- Drain to free_num_o=1, then alloc_req_i=2'b11 -> alloc_gnt_o=0 and no pointer move. alloc_req_i=2'b10 -> grant, alloc_tag_second_o = next tag, and fl_empty_o=1 afterward.
- Allocate 4 tags, commit 2, pulse flush_i -> free_num_o returns to FL_SIZE-2. The next allocation re-issues the 3rd and 4th originally allocated tags.
- Allocate 31 and free 31 with odd-sized groups, crossing the index 31->0 boundary -> tags returned in FIFO order including the straddling pair, with err_o=0.
- Same cycle: alloc 2'b11, free 2'b11, commit 2'b01 -> free_num_o unchanged next cycle. Freed tags appear only after the current tail contents.
- Free from a full list -> err_o=1, tail unchanged, free_num_o=FL_SIZE. rst_n=0 clears err_o.

Source files
------------

// File: rtl/preg_freelist_2w.sv
// Dual-ported physical register free list: speculative rename pops, commit-side pushes,
// and single-cycle flush recovery of the speculative read pointer.
module preg_freelist_2w #(
   parameter int FL_SIZE        = 32,
   parameter int FL_SIZE_WIDTH  = 5,
   parameter int TAG_WIDTH      = 6,
   parameter int FIRST_FREE_TAG = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               alloc_req_i,
   output logic                     alloc_gnt_o,
   output logic [TAG_WIDTH-1:0]     alloc_tag_first_o,
   output logic [TAG_WIDTH-1:0]     alloc_tag_second_o,
   input  logic [1:0]               commit_i,
   input  logic [1:0]               free_i,
   input  logic [TAG_WIDTH-1:0]     free_tag_first_i,
   input  logic [TAG_WIDTH-1:0]     free_tag_second_i,
   input  logic                     flush_i,
   output logic [FL_SIZE_WIDTH:0]   free_num_o,
   output logic                     fl_empty_o,
   output logic                     fl_almost_empty_o,
   output logic                     err_o
);
   localparam int PW = FL_SIZE_WIDTH + 1;

   logic [TAG_WIDTH-1:0]     queue [FL_SIZE];
   logic [PW-1:0]            spec_head, com_head, tail;
   logic [PW-1:0]            free_num, com_cnt, in_flight;
   logic [PW-1:0]            n_alloc, n_commit, n_free;
   logic [PW-1:0]            com_head_nxt;
   logic [FL_SIZE_WIDTH-1:0] rd_idx0, rd_idx1, wr_idx0, wr_idx1;
   logic                     alloc_gnt, commit_err, free_err;

   // Handshake: alloc_req_i lanes are requests; alloc_gnt_o acknowledges all requested
   // lanes together in the same cycle, and the tags are meaningful only while it is high.
   always_comb begin
      n_alloc   = PW'(alloc_req_i[0]) + PW'(alloc_req_i[1]);
      n_commit  = PW'(commit_i[0]) + PW'(commit_i[1]);
      n_free    = PW'(free_i[0]) + PW'(free_i[1]);
      free_num  = tail - spec_head;
      com_cnt   = tail - com_head;
      in_flight = spec_head - com_head;
      rd_idx0   = spec_head[FL_SIZE_WIDTH-1:0];
      rd_idx1   = rd_idx0 + FL_SIZE_WIDTH'(1);
      wr_idx0   = tail[FL_SIZE_WIDTH-1:0];
      wr_idx1   = wr_idx0 + FL_SIZE_WIDTH'(1);
      alloc_gnt = (n_alloc != '0) && (free_num >= n_alloc) && !flush_i;

      alloc_tag_first_o  = '0;
      alloc_tag_second_o = '0;
      if (alloc_req_i[0])
         alloc_tag_first_o = queue[rd_idx0];
      if (alloc_req_i[1])
         alloc_tag_second_o = alloc_req_i[0] ? queue[rd_idx1] : queue[rd_idx0];

      free_err     = ({1'b0, com_cnt} + {1'b0, n_free}) > (PW+1)'(FL_SIZE);
      commit_err   = n_commit > in_flight;
      com_head_nxt = commit_err ? spec_head : com_head + n_commit;
   end

   assign alloc_gnt_o       = alloc_gnt;
   assign free_num_o        = free_num;
   assign fl_empty_o        = (free_num == '0);
   assign fl_almost_empty_o = (free_num <= PW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FL_SIZE; i++)
            queue[i] <= TAG_WIDTH'(FIRST_FREE_TAG + i);
         spec_head <= '0;
         com_head  <= '0;
         tail      <= PW'(FL_SIZE);
         err_o     <= 1'b0;
      end else begin
         com_head <= com_head_nxt;
         // Flush rewinds to the committed point including this cycle's commits.
         if (flush_i)
            spec_head <= com_head_nxt;
         else if (alloc_gnt)
            spec_head <= spec_head + n_alloc;

         if (!free_err) begin
            case (free_i)
               2'b01: queue[wr_idx0] <= free_tag_first_i;
               2'b10: queue[wr_idx0] <= free_tag_second_i;
               2'b11: begin
                  queue[wr_idx0] <= free_tag_first_i;
                  queue[wr_idx1] <= free_tag_second_i;
               end
               default: ;
            endcase
            tail <= tail + n_free;
         end

         if (free_err || commit_err)
            err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_preg_freelist_2w.sv
// Self-checking bench for preg_freelist_2w: a list-based reference model plus a
// scoreboard queue of expected allocation tags.
module tb_preg_freelist_2w;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] alloc_req_i;
   logic       alloc_gnt_o;
   logic [5:0] alloc_tag_first_o, alloc_tag_second_o;
   logic [1:0] commit_i, free_i;
   logic [5:0] free_tag_first_i, free_tag_second_i;
   logic       flush_i;
   logic [5:0] free_num_o;
   logic       fl_empty_o, fl_almost_empty_o, err_o;

   preg_freelist_2w dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .alloc_req_i       (alloc_req_i),
      .alloc_gnt_o       (alloc_gnt_o),
      .alloc_tag_first_o (alloc_tag_first_o),
      .alloc_tag_second_o(alloc_tag_second_o),
      .commit_i          (commit_i),
      .free_i            (free_i),
      .free_tag_first_i  (free_tag_first_i),
      .free_tag_second_i (free_tag_second_i),
      .flush_i           (flush_i),
      .free_num_o        (free_num_o),
      .fl_empty_o        (fl_empty_o),
      .fl_almost_empty_o (fl_almost_empty_o),
      .err_o             (err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: ml holds tags from the committed head up to the tail, in order;
   // the first m_off of them are allocated but not yet committed.
   logic [5:0] ml[$];
   int         m_off;
   bit         m_err;
   logic [5:0] exp_q[$];

   logic       obs_gnt, obs_empty, obs_err;
   logic [5:0] obs_t0, obs_t1, obs_fn;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pc(input logic [1:0] v);
      return int'(v[0]) + int'(v[1]);
   endfunction

   task automatic model_reset();
      ml.delete();
      for (int i = 0; i < 32; i++) ml.push_back(6'(32 + i));
      m_off = 0;
      m_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      alloc_req_i      = 2'($urandom_range(0, 3));
      commit_i         = 2'($urandom_range(0, 3));
      free_i           = 2'($urandom_range(0, 3));
      free_tag_first_i = 6'($urandom_range(0, 63));
      free_tag_second_i= 6'($urandom_range(0, 63));
      flush_i          = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      alloc_req_i = '0; commit_i = '0; free_i = '0; flush_i = 1'b0;
      model_reset();
   endtask

   task automatic step(input logic [1:0] req, input logic [1:0] cmt, input logic [1:0] fr,
                       input logic [5:0] t0, input logic [5:0] t1, input logic fl);
      int na, nc, nf, avail, pre_off, pre_size, ncm;
      bit eg;
      alloc_req_i = req; commit_i = cmt; free_i = fr;
      free_tag_first_i = t0; free_tag_second_i = t1; flush_i = fl;
      @(negedge clk);
      na    = pc(req);
      nc    = pc(cmt);
      nf    = pc(fr);
      avail = ml.size() - m_off;
      eg    = (na != 0) && (avail >= na) && !fl;
      obs_gnt = alloc_gnt_o; obs_t0 = alloc_tag_first_o; obs_t1 = alloc_tag_second_o;
      obs_fn = free_num_o; obs_empty = fl_empty_o; obs_err = err_o;
      chk("gnt", 32'(alloc_gnt_o), 32'(eg));
      chk("free_num", 32'(free_num_o), 32'(avail));
      chk("empty", 32'(fl_empty_o), 32'(avail == 0));
      chk("almost_empty", 32'(fl_almost_empty_o), 32'(avail <= 1));
      chk("err", 32'(err_o), 32'(m_err));
      if (!req[0]) chk("tag_first_idle", 32'(alloc_tag_first_o), 32'(0));
      if (!req[1]) chk("tag_second_idle", 32'(alloc_tag_second_o), 32'(0));
      if (eg) begin
         if (req[0]) exp_q.push_back(ml[m_off]);
         if (req[1]) exp_q.push_back(ml[m_off + (req[0] ? 1 : 0)]);
         if (req[0]) chk("tag_first", 32'(alloc_tag_first_o), 32'(exp_q.pop_front()));
         if (req[1]) chk("tag_second", 32'(alloc_tag_second_o), 32'(exp_q.pop_front()));
      end
      pre_off  = m_off;
      pre_size = ml.size();
      if (nc > pre_off) begin
         m_err = 1'b1;
         ncm   = pre_off;
      end else begin
         ncm = nc;
      end
      repeat (ncm) void'(ml.pop_front());
      m_off = pre_off - ncm + (eg ? na : 0);
      if (fl) m_off = 0;
      if (pre_size + nf > 32) begin
         m_err = 1'b1;
      end else begin
         if (fr[0]) ml.push_back(t0);
         if (fr[1]) ml.push_back(fr[0] ? t1 : t1);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
   endtask

   // kind 0: allocate, 1: commit, 2: free random tags; groups of 1 or 2 until total is reached.
   task automatic run_group(input int kind, input int total, input bit pairs_only);
      int left;
      logic [1:0] p;
      left = total;
      while (left > 0) begin
         if (pairs_only && left >= 2) p = 2'b11;
         else if (left >= 2)          p = 2'($urandom_range(1, 3));
         else                         p = 2'($urandom_range(1, 2));
         case (kind)
            0: step(p, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
            1: step(2'b00, p, 2'b00, 6'd0, 6'd0, 1'b0);
            default: step(2'b00, 2'b00, p, 6'($urandom_range(0, 63)),
                          6'($urandom_range(0, 63)), 1'b0);
         endcase
         left -= pc(p);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      do_reset();

      // Reset state and first paired allocation.
      idle();
      chk("reset_free_num", 32'(obs_fn), 32'd32);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("first_gnt", 32'(obs_gnt), 32'd1);
      chk("first_tag0", 32'(obs_t0), 32'd32);
      chk("first_tag1", 32'(obs_t1), 32'd33);
      idle();
      chk("after_pair_free_num", 32'(obs_fn), 32'd30);

      // Drain to one entry, then an over-sized request must be refused.
      repeat (14) step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      step(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("short_pair_gnt", 32'(obs_gnt), 32'd0);
      step(2'b10, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("lone_second_gnt", 32'(obs_gnt), 32'd1);
      chk("lone_second_tag", 32'(obs_t1), 32'd63);
      idle();
      chk("drained_empty", 32'(obs_empty), 32'd1);
      step(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);

      // Flush reclaims uncommitted allocations.
      do_reset();
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      step(2'b00, 2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b1);
      idle();
      chk("flush_free_num", 32'(obs_fn), 32'd30);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("reissue_tag0", 32'(obs_t0), 32'd34);
      chk("reissue_tag1", 32'(obs_t1), 32'd35);

      // Wrap-around of both read and write pointers, including straddling pairs.
      do_reset();
      run_group(0, 31, 1'b0);
      run_group(1, 31, 1'b0);
      run_group(2, 31, 1'b0);
      run_group(0, 32, 1'b1);
      run_group(1, 32, 1'b1);
      run_group(2, 32, 1'b1);
      run_group(0, 32, 1'b0);
      idle();
      chk("wrap_err", 32'(obs_err), 32'd0);

      // Simultaneous alloc, free and commit.
      run_group(1, 6, 1'b1);
      step(2'b00, 2'b00, 2'b11, 6'd1, 6'd2, 1'b0);
      step(2'b00, 2'b00, 2'b11, 6'd3, 6'd4, 1'b0);
      step(2'b11, 2'b01, 2'b11, 6'd5, 6'd9, 1'b0);
      chk("same_cycle_tag0", 32'(obs_t0), 32'd1);
      idle();
      chk("same_cycle_free_num", 32'(obs_fn), 32'd4);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("old_tail_tag0", 32'(obs_t0), 32'd3);
      step(2'b11, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("new_free_tag0", 32'(obs_t0), 32'd5);
      chk("new_free_tag1", 32'(obs_t1), 32'd9);

      // Random mix, including flushes and possible protocol errors.
      do_reset();
      for (int i = 0; i < 200; i++)
         step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
              1'($urandom_range(0, 15) == 0));

      // Free into a full list, then over-commit, then reset clears the sticky flag.
      do_reset();
      step(2'b00, 2'b00, 2'b01, 6'd7, 6'd0, 1'b0);
      idle();
      chk("overfree_err", 32'(obs_err), 32'd1);
      chk("overfree_free_num", 32'(obs_fn), 32'd32);
      do_reset();
      step(2'b00, 2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
      idle();
      chk("overcommit_err", 32'(obs_err), 32'd1);
      do_reset();
      idle();
      chk("reset_clears_err", 32'(obs_err), 32'd0);
      step(2'b01, 2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
      chk("post_reset_tag", 32'(obs_t0), 32'd32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
